// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - shared FP32 types, constants and divider state encodings
package fp32_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp32_t;

    localparam int          FP32_BIAS    = 127;
    localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  FP32_INF_EXP = 8'hFF;

    // Quotient bits developed per operation (24 mantissa + guard + one for normalisation)
    localparam int QBITS   = 26;
    // Accepting edge to out_valid: QBITS divide cycles plus one rounding cycle
    localparam int LATENCY = QBITS + 1;

    typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} div_state_e;
    typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_e;

endpackage

// File: rtl/fp32_div_iter_if.sv
// rtl/fp32_div_iter_if.sv - operand/result handshake bundle for the FP32 divider
interface fp32_div_iter_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] div1;
    logic [31:0] div2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [3:0]  flags;

    modport master (
        output in_valid, div1, div2, out_ready,
        input  in_ready, out_valid, quotient, flags
    );

    modport slave (
        input  in_valid, div1, div2, out_ready,
        output in_ready, out_valid, quotient, flags
    );
endinterface

// File: rtl/fp32_div_special.sv
// rtl/fp32_div_special.sv - classifies divide operands into special-case results
module fp32_div_special
    import fp32_pkg::*;
(
    input  logic [7:0]  a_exp,
    input  logic [22:0] a_man,
    input  logic [7:0]  b_exp,
    input  logic [22:0] b_man,
    output special_e    sp,
    output logic        invalid,
    output logic        div_by_zero
);

    logic a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;

    // Denormals (exp==0) are classed as zero
    always_comb begin
        a_nan  = (a_exp == FP32_INF_EXP) && (a_man != '0);
        a_inf  = (a_exp == FP32_INF_EXP) && (a_man == '0);
        a_zero = (a_exp == 8'h00);
        b_nan  = (b_exp == FP32_INF_EXP) && (b_man != '0);
        b_inf  = (b_exp == FP32_INF_EXP) && (b_man == '0);
        b_zero = (b_exp == 8'h00);
    end

    // Priority: NaN-producing cases, inf dividend, divide by zero, zero result
    always_comb begin
        sp          = SP_NONE;
        invalid     = 1'b0;
        div_by_zero = 1'b0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            sp      = SP_NAN;
            invalid = 1'b1;
        end else if (a_inf) begin
            sp = SP_INF;
        end else if (b_zero) begin
            sp          = SP_INF;
            div_by_zero = 1'b1;
        end else if (a_zero || b_inf) begin
            sp = SP_ZERO;
        end
    end

endmodule

// File: rtl/fp32_div_iter.sv
// rtl/fp32_div_iter.sv - iterative radix-2 restoring FP32 divider, one quotient bit per clock
module fp32_div_iter
    import fp32_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    fp32_div_iter_if.slave    bus
);

    div_state_e       state, state_nxt;
    logic [4:0]       cnt;
    logic             sign_r, inv_r, dbz_r;
    special_e         sp_r;
    logic [23:0]      m2_r;
    logic [24:0]      rem_r;
    logic [25:0]      q_r;
    logic signed [9:0] exp_r;
    logic [31:0]      quot_r;
    logic [3:0]       flags_r;

    fp32_t            a, b;
    special_e         sp_in;
    logic             inv_in, dbz_in;
    logic signed [9:0] exp_in;

    logic             ge;
    logic [24:0]      rem_diff;

    logic [23:0]      man_pre;
    logic [22:0]      man_rnd;
    logic             guard, sticky, inc, carry;
    logic signed [9:0] exp_adj, exp_fin;
    logic [31:0]      res_q;
    logic [3:0]       res_f;

    assign a = bus.div1;
    assign b = bus.div2;

    fp32_div_special u_special (
        .a_exp       (a.exp),
        .a_man       (a.man),
        .b_exp       (b.exp),
        .b_man       (b.man),
        .sp          (sp_in),
        .invalid     (inv_in),
        .div_by_zero (dbz_in)
    );

    // Biased exponent difference, kept signed so over/underflow show up after rounding
    always_comb begin
        exp_in = $signed({2'b00, a.exp}) - $signed({2'b00, b.exp}) + 10'(FP32_BIAS);
    end

    // One restoring step: subtract the divisor when it fits
    always_comb begin
        ge       = (rem_r >= {1'b0, m2_r});
        rem_diff = ge ? (rem_r - {1'b0, m2_r}) : rem_r;
    end

    // Normalise, round to nearest even and form the packed result
    always_comb begin
        if (q_r[25]) begin
            man_pre = q_r[25:2];
            guard   = q_r[1];
            sticky  = q_r[0] | (rem_r != '0);
            exp_adj = exp_r;
        end else begin
            man_pre = q_r[24:1];
            guard   = q_r[0];
            sticky  = (rem_r != '0);
            exp_adj = exp_r - 10'sd1;
        end
        inc     = guard && (sticky || man_pre[0]);
        carry   = inc && (&man_pre);
        man_rnd = man_pre[22:0] + {22'd0, inc};
        exp_fin = carry ? (exp_adj + 10'sd1) : exp_adj;

        res_q = '0;
        res_f = '0;
        case (sp_r)
            SP_NAN: begin
                res_q = FP32_QNAN;
                res_f = {inv_r, 3'b000};
            end
            SP_INF: begin
                res_q = {sign_r, FP32_INF_EXP, 23'd0};
                res_f = {1'b0, dbz_r, 2'b00};
            end
            SP_ZERO: begin
                res_q = {sign_r, 31'd0};
            end
            default: begin
                if (exp_fin >= 10'sd255) begin
                    res_q = {sign_r, FP32_INF_EXP, 23'd0};
                    res_f = 4'b0010;
                end else if (exp_fin <= 10'sd0) begin
                    res_q = {sign_r, 31'd0};
                    res_f = 4'b0001;
                end else begin
                    res_q = {sign_r, exp_fin[7:0], man_rnd};
                end
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)           state_nxt = DIVIDE;
            DIVIDE:  if (cnt == 5'(QBITS - 1))   state_nxt = ROUND;
            ROUND:                               state_nxt = DONE;
            DONE:    if (bus.out_ready)          state_nxt = IDLE;
            default:                             state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.quotient  = quot_r;
        bus.flags     = flags_r;
    end

    // Operand capture, quotient iteration and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            sign_r  <= 1'b0;
            inv_r   <= 1'b0;
            dbz_r   <= 1'b0;
            sp_r    <= SP_NONE;
            m2_r    <= '0;
            rem_r   <= '0;
            q_r     <= '0;
            exp_r   <= '0;
            quot_r  <= '0;
            flags_r <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    cnt    <= '0;
                    sign_r <= a.sign ^ b.sign;
                    sp_r   <= sp_in;
                    inv_r  <= inv_in;
                    dbz_r  <= dbz_in;
                    m2_r   <= {b.exp != 8'h00, b.man};
                    rem_r  <= {1'b0, a.exp != 8'h00, a.man};
                    q_r    <= '0;
                    exp_r  <= exp_in;
                end
                DIVIDE: begin
                    cnt   <= cnt + 5'd1;
                    q_r   <= {q_r[24:0], ge};
                    rem_r <= rem_diff << 1;
                end
                ROUND: begin
                    quot_r  <= res_q;
                    flags_r <= res_f;
                end
                default: ;
            endcase
        end
    end

endmodule
